// File: rtl/gprs_wb_queue.sv
// Writeback queue for the 8x16 register file: merges ALU and load write
// requests into an in-order FIFO that drives the single write port and flags read hazards.
module gprs_wb_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 16,
    parameter int AW    = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         alu_valid,
    output logic                         alu_ready,
    input  logic [AW-1:0]                alu_ws,
    input  logic [DW-1:0]                alu_wd,
    input  logic                         mem_valid,
    output logic                         mem_ready,
    input  logic [AW-1:0]                mem_ws,
    input  logic [DW-1:0]                mem_wd,
    input  logic                         wb_stall,
    output logic [AW-1:0]                ws,
    output logic [DW-1:0]                wd,
    output logic                         we,
    input  logic [AW-1:0]                rs1,
    input  logic [AW-1:0]                rs2,
    output logic                         hazard1,
    output logic                         hazard2,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [AW-1:0] ws;
        logic [DW-1:0] wd;
    } wb_req_t;

    wb_req_t                alu_req, mem_req, head;
    wb_req_t [DEPTH-1:0]    slot_q;
    logic    [DEPTH-1:0]    slot_vld, hit1, hit2;
    logic    [PW-1:0]       wr_ptr, rd_ptr, alu_ptr;
    logic    [CW:0]         free;
    logic    [1:0]          n_acc;
    logic                   pop, mem_acc, alu_acc, nonempty;

    assign alu_req  = '{ws: alu_ws, wd: alu_wd};
    assign mem_req  = '{ws: mem_ws, wd: mem_wd};
    assign nonempty = (count != '0);

    assign we   = nonempty & ~wb_stall;
    assign pop  = we;
    assign head = slot_q[rd_ptr];
    assign ws   = nonempty ? head.ws : '0;
    assign wd   = nonempty ? head.wd : '0;

    // Slot freed by this edge's pop counts as space, so a full queue still accepts while draining.
    assign free      = (CW+1)'(DEPTH) - {1'b0, count} + {{CW{1'b0}}, pop};
    assign mem_ready = (free >= (CW+1)'(1));
    assign alu_ready = (free >= (CW+1)'(2)) || ((free >= (CW+1)'(1)) && !mem_valid);

    assign mem_acc = mem_valid & mem_ready;
    assign alu_acc = alu_valid & alu_ready;
    assign n_acc   = {1'b0, mem_acc} + {1'b0, alu_acc};
    // The load request takes the lower slot when both arrive together.
    assign alu_ptr = wr_ptr + PW'(mem_acc);

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        logic    hit_mem, hit_alu, vld;
        wb_req_t q;

        assign hit_mem = mem_acc && (wr_ptr  == PW'(g));
        assign hit_alu = alu_acc && (alu_ptr == PW'(g));

        // Clear before set: at full occupancy a push may refill the slot being popped.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                vld <= 1'b0;
                q   <= '0;
            end else begin
                if (pop && (rd_ptr == PW'(g)))
                    vld <= 1'b0;
                if (hit_mem || hit_alu) begin
                    vld <= 1'b1;
                    q   <= hit_mem ? mem_req : alu_req;
                end
            end
        end

        assign slot_vld[g] = vld;
        assign slot_q[g]   = q;
        assign hit1[g]     = vld && (q.ws == rs1);
        assign hit2[g]     = vld && (q.ws == rs2);
    end

    assign hazard1 = |hit1;
    assign hazard2 = |hit2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(n_acc);
            rd_ptr <= rd_ptr + PW'(pop);
            count  <= count + CW'(n_acc) - CW'(pop);
        end
    end

endmodule

// File: doc/gprs_wb_queue.md
Name: gprs_wb_queue

Overview:
Writeback initiator for the 8x16 general-purpose register file. It accepts register-write requests from two producers, the ALU and the memory/load path, through valid/ready handshakes. Requests are buffered in a small in-order FIFO and drive the register file's single write port (ws/wd/we) at one write per cycle. It also reports pending-write hazards for the two read addresses, so the decode stage can stall.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2
DW, 16, register data width
AW, 3, register address width (8 registers)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
alu_valid  in  1  ALU write request valid
alu_ready  out  1  ALU request accepted this edge when valid&ready
alu_ws  in  AW  ALU destination register
alu_wd  in  DW  ALU write data
mem_valid  in  1  load write request valid
mem_ready  out  1  load request accepted this edge when valid&ready
mem_ws  in  AW  load destination register
mem_wd  in  DW  load write data
wb_stall  in  1  write port unavailable this cycle; hold head entry
ws  out  AW  register-file write address (FIFO head)
wd  out  DW  register-file write data (FIFO head)
we  out  1  register-file write enable
rs1  in  AW  read address 1 being decoded
rs2  in  AW  read address 2 being decoded
hazard1  out  1  a queued entry targets rs1
hazard2  out  1  a queued entry targets rs2
count  out  $clog2(DEPTH+1)  number of occupied entries

Behaviour:
- Storage: DEPTH entries of {ws[AW], wd[DW]}; wr_ptr and rd_ptr wrap modulo DEPTH; count register is 0..DEPTH.
- Reset (reset=0, asynchronous):
  - wr_ptr, rd_ptr and count clear to 0; all entries are invalidated.
  - Immediately: we=0, ws=0, wd=0, hazard1=hazard2=0, alu_ready=mem_ready=1.
  - Reset mid-operation discards queued entries; they are never written.
- Head output (combinational):
  - we = (count!=0) & ~wb_stall.
  - ws/wd = head entry when count!=0, else 0.
- pop = we. The head is retired on the same rising edge on which the register file captures it.
- Ready (combinational): let free = DEPTH - count + pop.
  - mem_ready = (free >= 1).
  - alu_ready = (free >= 2), or (free >= 1) when mem_valid=0.
  - Neither ready depends on the source's own valid.
- Enqueue order on one edge:
  - The mem request is accepted first, then the alu request. Both may be accepted on the same edge.
  - If both are accepted, the mem entry occupies wr_ptr and the alu entry occupies wr_ptr+1. wr_ptr advances by the number accepted (0, 1 or 2).
- count_next = count + accepted - pop. Push and pop on the same edge are allowed, including at count=DEPTH, where pop frees the slot.
- Latency:
  - Request accepted at edge N into an empty queue with wb_stall=0 → we=1 during cycle N→N+1 → register written at edge N+1.
  - The FIFO is never bypassed.
- Ordering: strict FIFO. Two queued writes to the same register both issue in order, so the later one wins. There is no coalescing. R0 is treated like any other register.
- Backpressure: if valid=1 and ready=0, the request is not taken. The source holds ws/wd/valid stable. The queue never overflows or underflows.
- wb_stall=1: we=0, no pop, and the head is held. Enqueues still proceed while space remains.
- Hazards (combinational):
  - hazard1 = OR over occupied entries of (entry.ws == rs1); hazard2 likewise for rs2.
  - The head entry counts, even while we=1.
  - Entries being enqueued on the current edge are not yet visible.

Test Plan:
1. Assert reset=0 mid-cycle → we=0, count=0, alu_ready=mem_ready=1, immediately; release → unchanged with no requests.
2. ALU R3=0x1234 accepted at edge N → cycle after N: ws=3, wd=0x1234, we=1; edge N+1: count returns to 0, we=0.
3. Same edge: mem R1=0xAAAA and alu R2=0x5555 → count=2; next cycle ws=1/wd=0xAAAA; following cycle ws=2/wd=0x5555; then we=0.
4. wb_stall=1, enqueue 4 writes (R4..R7, data 0x0004..0x0007) → count=4, mem_ready=alu_ready=0, we=0; drop stall → 4 consecutive writes R4..R7 in order, count 4→0.
5. Queue holds R5=0xBEEF with wb_stall=1, rs1=5, rs2=4 → hazard1=1, hazard2=0; release stall → after pop hazard1=0.
6. Ten back-to-back single ALU writes R0..R7,R0,R1 (data = index) across pointer wrap with random wb_stall → exactly ten writes, in order, correct data, no drops, no duplicates.
7. Assert reset with 3 entries queued → we=0 and count=0 immediately; no queued entry is written after reset releases.
